// File: rtl/cipher_arbiter.sv
// Round-robin arbiter sharing one block-cipher core between NUM_REQ requesters.
// One transaction at a time: accept, start the core, wait for done or timeout, respond.
module cipher_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 64,
  parameter int TIMEOUT    = 1023,
  parameter int ID_W       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*KEY_SIZE-1:0]    req_key,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [BLOCK_SIZE-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           cipher_start,
  output logic [KEY_SIZE-1:0]            cipher_key,
  output logic [BLOCK_SIZE-1:0]          cipher_pt,
  input  logic [BLOCK_SIZE-1:0]          cipher_ct,
  input  logic                           cipher_done,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id
);

  localparam int TIMER_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic [BLOCK_SIZE-1:0] pt_q, pt_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BLOCK_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [KEY_SIZE-1:0]   key_arr  [NUM_REQ];
  logic [BLOCK_SIZE-1:0] data_arr [NUM_REQ];
  logic [ID_W-1:0]       winner;
  logic                  found;
  logic [ID_W:0]         cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign key_arr[g]  = req_key[g*KEY_SIZE +: KEY_SIZE];
    assign data_arr[g] = req_data[g*BLOCK_SIZE +: BLOCK_SIZE];
  end

  // Search starts one past the last owner and wraps, giving round-robin fairness.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ-1);
      owner_q      <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      timer_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      timer_q      <= timer_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    key_d        = key_q;
    pt_d         = pt_q;
    timer_d      = timer_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          key_d   = key_arr[winner];
          pt_d    = data_arr[winner];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (cipher_done) begin
          rsp_data_d = cipher_ct;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT-1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    cipher_start = 1'b0;
    busy         = (state_q != IDLE);
    grant_id     = '0;
    if (state_q == IDLE && found) req_ready = NUM_REQ'(1) << winner;
    if (state_q == RESP) rsp_valid = NUM_REQ'(1) << owner_q;
    if (state_q == ISSUE) cipher_start = 1'b1;
    if (state_q != IDLE) grant_id = owner_q;
  end

  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign cipher_key = key_q;
  assign cipher_pt  = pt_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
// Directed self-checking bench for cipher_arbiter with a small cipher core model
// that answers pt^key a programmable number of cycles after start.
module tb_cipher_arbiter;

  localparam int NR = 4;
  localparam int BS = 64;
  localparam int KS = 64;
  localparam int TO = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*KS-1:0] req_key;
  logic [NR*BS-1:0] req_data;
  logic [NR-1:0]  rsp_valid;
  logic [NR-1:0]  rsp_ready;
  logic [BS-1:0]  rsp_data;
  logic           rsp_err;
  logic           cipher_start;
  logic [KS-1:0]  cipher_key;
  logic [BS-1:0]  cipher_pt;
  logic [BS-1:0]  cipher_ct;
  logic           cipher_done;
  logic           busy;
  logic [IW-1:0]  grant_id;

  logic           model_done;
  logic           manual_done;
  int             model_delay;
  int             checks;
  int             errors;
  int             start_count;
  int             multi_hot;

  logic [KS-1:0]  keys   [NR];
  logic [BS-1:0]  blocks [NR];

  assign req_key     = {keys[3], keys[2], keys[1], keys[0]};
  assign req_data    = {blocks[3], blocks[2], blocks[1], blocks[0]};
  assign cipher_done = model_done | manual_done;

  cipher_arbiter #(
    .NUM_REQ(NR), .BLOCK_SIZE(BS), .KEY_SIZE(KS), .TIMEOUT(TO), .ID_W(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cipher_start(cipher_start), .cipher_key(cipher_key), .cipher_pt(cipher_pt),
    .cipher_ct(cipher_ct), .cipher_done(cipher_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Core model: done goes high D cycles after the start cycle; negative D never answers.
  initial begin : core_model
    int cnt;
    logic [KS-1:0] mkey;
    logic [BS-1:0] mpt;
    cnt = -1;
    mkey = '0;
    mpt = '0;
    model_done = 1'b0;
    cipher_ct = '0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          cipher_ct = mpt ^ mkey;
          cnt = -1;
        end
      end
      if (cipher_start) begin
        cnt = model_delay;
        mkey = cipher_key;
        mpt = cipher_pt;
      end
    end
  end

  always @(negedge clk) begin
    if (cipher_start) start_count++;
    if ($countones(req_ready) > 1) multi_hot++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_start"}, 64'(cipher_start), 64'd0);
    checkOutput({tag, "_key"}, cipher_key, 64'd0);
    checkOutput({tag, "_pt"}, cipher_pt, 64'd0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 64'd0);
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  // Called at an IDLE cycle with the request already driven; ends back in IDLE.
  task automatic serveOne(input int id, input int lat, input logic err,
                          input logic [63:0] exp_data, input bit drop);
    int s0;
    int n;
    logic [63:0] onehot;
    onehot = 64'd1 << id;
    checkOutput("accept_req_ready", 64'(req_ready), onehot);
    s0 = start_count;
    @(negedge clk); #1;
    checkOutput("issue_start", 64'(cipher_start), 64'd1);
    checkOutput("issue_req_ready", 64'(req_ready), 64'd0);
    checkOutput("issue_grant_id", 64'(grant_id), 64'(id));
    checkOutput("issue_key", cipher_key, keys[id]);
    checkOutput("issue_pt", cipher_pt, blocks[id]);
    if (drop) req_valid[id] = 1'b0;
    n = 1;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("rsp_latency", 64'(n), 64'(lat));
    checkOutput("rsp_valid", 64'(rsp_valid), onehot);
    checkOutput("rsp_err", 64'(rsp_err), 64'(err));
    checkOutput("rsp_data", rsp_data, exp_data);
    checkOutput("start_pulses", 64'(start_count - s0), 64'd1);
    rsp_ready = NR'(onehot);
    @(negedge clk); #1;
    rsp_ready = '0;
    checkOutput("after_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("after_busy", 64'(busy), 64'd0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    checks = 0;
    errors = 0;
    start_count = 0;
    multi_hot = 0;
    model_delay = 5;
    manual_done = 1'b0;
    reset = 1'b1;
    applyStimulus('0, '0);
    keys[0] = 64'h0011223344556677;  blocks[0] = 64'hFFEEDDCCBBAA9988;
    keys[1] = 64'h0123456789ABCDEF;  blocks[1] = 64'h1111111111111111;
    keys[2] = 64'hCAFEBABEDEADBEEF;  blocks[2] = 64'h5555AAAA5555AAAA;
    keys[3] = 64'h8000000000000001;  blocks[3] = 64'h7FFFFFFFFFFFFFFE;

    resetDut();
    checkAllZero("reset");

    $display("[TB] single request from requester 1");
    @(negedge clk); #1;
    model_delay = 5;
    applyStimulus(4'b0010, '0);
    #1;
    serveOne(1, 7, 1'b0, 64'h1032547698BADCFE, 1'b1);

    $display("[TB] round robin with all requesters active");
    @(negedge clk); #1;
    resetDut();
    model_delay = 2;
    applyStimulus(4'b1111, '0);
    #1;
    for (int i = 0; i < 8; i++) serveOne(i % NR, 4, 1'b0, keys[i % NR] ^ blocks[i % NR], 1'b0);
    applyStimulus('0, '0);
    checkOutput("multi_hot_req_ready", 64'(multi_hot), 64'd0);

    $display("[TB] timeout then normal request");
    model_delay = -1;
    applyStimulus(4'b0100, '0);
    #1;
    serveOne(2, 2 + TO, 1'b1, 64'd0, 1'b1);
    model_delay = 3;
    applyStimulus(4'b1000, '0);
    #1;
    serveOne(3, 5, 1'b0, keys[3] ^ blocks[3], 1'b1);

    $display("[TB] done on the timeout cycle");
    model_delay = TO;
    applyStimulus(4'b0001, '0);
    #1;
    serveOne(0, 2 + TO, 1'b0, keys[0] ^ blocks[0], 1'b1);

    $display("[TB] response back-pressure");
    model_delay = 1;
    applyStimulus(4'b0010, '0);
    #1;
    checkOutput("bp_accept", 64'(req_ready), 64'b0010);
    @(negedge clk); #1;
    req_valid = '0;
    n = 1;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("bp_latency", 64'(n), 64'd3);
    s0 = start_count;
    applyStimulus(4'b1101, 4'b1101);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
      checkOutput("bp_rsp_data", rsp_data, keys[1] ^ blocks[1]);
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
    end
    checkOutput("bp_no_start", 64'(start_count - s0), 64'd0);
    rsp_ready = 4'b0010;
    @(negedge clk); #1;
    rsp_ready = '0;
    checkOutput("bp_next_winner", 64'(req_ready), 64'b0100);
    serveOne(2, 3, 1'b0, keys[2] ^ blocks[2], 1'b1);
    applyStimulus('0, '0);

    $display("[TB] reset during WAIT with a late done");
    model_delay = -1;
    applyStimulus(4'b0100, '0);
    #1;
    checkOutput("rst_accept", 64'(req_ready), 64'b0100);
    @(negedge clk); #1;
    req_valid = '0;
    repeat (4) begin
      @(negedge clk); #1;
    end
    checkOutput("rst_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk); #1;
    reset = 1'b0;
    manual_done = 1'b1;
    @(negedge clk); #1;
    manual_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("late_done_busy", 64'(busy), 64'd0);
      checkOutput("late_done_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk); #1;
    end
    model_delay = 2;
    applyStimulus(4'b1111, '0);
    #1;
    serveOne(0, 4, 1'b0, keys[0] ^ blocks[0], 1'b1);
    applyStimulus('0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
